// File: rtl/mano_control_unit_if.sv
// Mano control unit bus: instruction/status inputs plus per-cycle datapath
// controls. master = control unit, slave = datapath side.
interface mano_control_unit_if #(
  parameter int ADDR_W = 12,
  parameter int OP_W   = 3,
  parameter int DATA_W = ADDR_W + 1 + OP_W
);
  logic              start;
  logic [DATA_W-1:0] ir;
  logic              ac_msb, ac_zero, e, dr_zero, fgi, fgo;

  logic [2:0]        sc;
  logic              running, ien, int_cycle;
  logic [2:0]        bus_sel;
  logic              ar_ld, ar_inc, ar_clr;
  logic              pc_ld, pc_inc, pc_clr;
  logic              dr_ld, dr_inc;
  logic              ir_ld, tr_ld, outr_ld;
  logic              mem_rd, mem_wr;
  logic              fgi_clr, fgo_clr;
  logic [3:0]        alu_op;

  modport master (
    input  start, ir, ac_msb, ac_zero, e, dr_zero, fgi, fgo,
    output sc, running, ien, int_cycle, bus_sel,
           ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc,
           ir_ld, tr_ld, outr_ld, mem_rd, mem_wr, fgi_clr, fgo_clr, alu_op
  );

  modport slave (
    output start, ir, ac_msb, ac_zero, e, dr_zero, fgi, fgo,
    input  sc, running, ien, int_cycle, bus_sel,
           ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc,
           ir_ld, tr_ld, outr_ld, mem_rd, mem_wr, fgi_clr, fgo_clr, alu_op
  );
endinterface

// File: rtl/mano_control_unit.sv
// Mano basic computer control unit: sequence counter, I/R/IEN/S flags and
// per-timing-step decode of bus select, register strobes and ALU op.
module mano_control_unit #(
  parameter int ADDR_W = 12,
  parameter int OP_W   = 3,
  parameter int DATA_W = ADDR_W + 1 + OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  mano_control_unit_if.master   bus
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} sc_t;

  localparam logic [2:0] B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3,
                         B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;

  sc_t  r_sc, w_sc_nxt;
  logic r_i, r_r, r_ien, r_s;
  logic w_i_nxt, w_r_nxt, w_ien_nxt, w_s_nxt;
  logic w_clr;

  logic [2:0] w_bus;
  logic [3:0] w_alu;
  logic w_ar_ld, w_ar_inc, w_ar_clr, w_pc_ld, w_pc_inc, w_pc_clr;
  logic w_dr_ld, w_dr_inc, w_ir_ld, w_tr_ld, w_outr_ld;
  logic w_mem_rd, w_mem_wr, w_fgi_clr, w_fgo_clr;

  logic [OP_W-1:0] w_op;
  logic [11:0]     w_fn;
  logic            w_ones;

  assign w_op   = bus.ir[DATA_W-2:ADDR_W];
  assign w_fn   = bus.ir[11:0];
  assign w_ones = &w_op;

  // State register: timing step and control flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc  <= T0;
      r_i   <= 1'b0;
      r_r   <= 1'b0;
      r_ien <= 1'b0;
      r_s   <= 1'b0;
    end else begin
      r_sc  <= w_sc_nxt;
      r_i   <= w_i_nxt;
      r_r   <= w_r_nxt;
      r_ien <= w_ien_nxt;
      r_s   <= w_s_nxt;
    end
  end

  // Decode of current step into strobes, plus next-state of counter and flags
  always_comb begin
    w_bus = B_NONE;  w_alu = 4'd0;
    w_ar_ld = 1'b0;  w_ar_inc = 1'b0;  w_ar_clr = 1'b0;
    w_pc_ld = 1'b0;  w_pc_inc = 1'b0;  w_pc_clr = 1'b0;
    w_dr_ld = 1'b0;  w_dr_inc = 1'b0;  w_ir_ld = 1'b0;
    w_tr_ld = 1'b0;  w_outr_ld = 1'b0;
    w_mem_rd = 1'b0; w_mem_wr = 1'b0;
    w_fgi_clr = 1'b0; w_fgo_clr = 1'b0;
    w_clr = 1'b0;
    w_i_nxt = r_i;  w_r_nxt = r_r;  w_ien_nxt = r_ien;  w_s_nxt = r_s;
    w_sc_nxt = T0;

    if (r_s) begin
      case (r_sc)
        T0: begin
          w_bus = B_PC;
          if (r_r) begin w_ar_clr = 1'b1; w_tr_ld = 1'b1; end
          else     w_ar_ld = 1'b1;
        end
        T1: begin
          if (r_r) begin
            w_bus = B_TR; w_mem_wr = 1'b1; w_pc_clr = 1'b1;
          end else begin
            w_bus = B_MEM; w_mem_rd = 1'b1; w_ir_ld = 1'b1; w_pc_inc = 1'b1;
          end
        end
        T2: begin
          if (r_r) begin
            w_pc_inc = 1'b1; w_ien_nxt = 1'b0; w_r_nxt = 1'b0; w_clr = 1'b1;
          end else begin
            w_bus = B_IR; w_ar_ld = 1'b1; w_i_nxt = bus.ir[DATA_W-1];
          end
        end
        T3: begin
          if (!w_ones) begin
            // indirect operand fetch; direct addressing idles this step
            if (r_i) begin w_bus = B_MEM; w_mem_rd = 1'b1; w_ar_ld = 1'b1; end
          end else if (!r_i) begin
            // register reference: highest set bit selects the ALU op
            if      (w_fn[11]) w_alu = 4'd4;
            else if (w_fn[10]) w_alu = 4'd5;
            else if (w_fn[9])  w_alu = 4'd6;
            else if (w_fn[8])  w_alu = 4'd7;
            else if (w_fn[7])  w_alu = 4'd8;
            else if (w_fn[6])  w_alu = 4'd9;
            else if (w_fn[5])  w_alu = 4'd10;
            w_pc_inc = (w_fn[4] & !bus.ac_msb) | (w_fn[3] & bus.ac_msb) |
                       (w_fn[2] & bus.ac_zero) | (w_fn[1] & !bus.e);
            if (w_fn[0]) w_s_nxt = 1'b0;
            w_clr = 1'b1;
          end else begin
            // I/O instruction; IOF ordered after ION so it wins
            if (w_fn[11]) begin w_alu = 4'd11; w_fgi_clr = 1'b1; end
            if (w_fn[10]) begin w_bus = B_AC; w_outr_ld = 1'b1; w_fgo_clr = 1'b1; end
            w_pc_inc = (w_fn[9] & bus.fgi) | (w_fn[8] & bus.fgo);
            if (w_fn[7]) w_ien_nxt = 1'b1;
            if (w_fn[6]) w_ien_nxt = 1'b0;
            w_clr = 1'b1;
          end
        end
        T4: begin
          case (int'(w_op))
            0, 1, 2, 6: begin w_bus = B_MEM; w_mem_rd = 1'b1; w_dr_ld = 1'b1; end
            3: begin w_bus = B_AC; w_mem_wr = 1'b1; w_clr = 1'b1; end
            4: begin w_bus = B_AR; w_pc_ld = 1'b1; w_clr = 1'b1; end
            5: begin w_bus = B_PC; w_mem_wr = 1'b1; w_ar_inc = 1'b1; end
            default: w_clr = 1'b1;
          endcase
        end
        T5: begin
          case (int'(w_op))
            0: begin w_alu = 4'd1; w_clr = 1'b1; end
            1: begin w_alu = 4'd2; w_clr = 1'b1; end
            2: begin w_alu = 4'd3; w_clr = 1'b1; end
            5: begin w_bus = B_AR; w_pc_ld = 1'b1; w_clr = 1'b1; end
            6: w_dr_inc = 1'b1;
            default: w_clr = 1'b1;
          endcase
        end
        T6: begin
          if (int'(w_op) == 6) begin
            w_bus = B_DR; w_mem_wr = 1'b1; w_pc_inc = bus.dr_zero;
          end
          w_clr = 1'b1;
        end
        default: w_clr = 1'b1;
      endcase

      // interrupt is only taken once the instruction fetch has completed
      if (r_sc >= T3 && r_ien && (bus.fgi | bus.fgo)) w_r_nxt = 1'b1;

      if (!w_clr) w_sc_nxt = sc_t'(r_sc + 3'd1);
    end

    if (bus.start) w_s_nxt = 1'b1;
  end

  // Drive the interface
  assign bus.sc        = r_sc;
  assign bus.running   = r_s;
  assign bus.ien       = r_ien;
  assign bus.int_cycle = r_r;
  assign bus.bus_sel   = w_bus;
  assign bus.alu_op    = w_alu;
  assign bus.ar_ld     = w_ar_ld;
  assign bus.ar_inc    = w_ar_inc;
  assign bus.ar_clr    = w_ar_clr;
  assign bus.pc_ld     = w_pc_ld;
  assign bus.pc_inc    = w_pc_inc;
  assign bus.pc_clr    = w_pc_clr;
  assign bus.dr_ld     = w_dr_ld;
  assign bus.dr_inc    = w_dr_inc;
  assign bus.ir_ld     = w_ir_ld;
  assign bus.tr_ld     = w_tr_ld;
  assign bus.outr_ld   = w_outr_ld;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.fgi_clr   = w_fgi_clr;
  assign bus.fgo_clr   = w_fgo_clr;
endmodule
